// File: rtl/gray_monitor_pkg.sv
// Shared constants for the Gray counter / Gray monitor pair: default code width
// and the monitor's FSM state encodings.
package gray_monitor_pkg;

  localparam int GRAY_WIDTH = 3;

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

endpackage

// File: rtl/gray_monitor_if.sv
// Sample/status bundle between a Gray code source (master) and the monitor (slave).
interface gray_monitor_if
  import gray_monitor_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int CNT_W = 4
);

  logic             en;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] binary;
  logic             valid;
  logic             step;
  logic             overflow;
  logic [CNT_W-1:0] wrap_cnt;
  logic             error;

  modport master (
    output en, gray,
    input  binary, valid, step, overflow, wrap_cnt, error
  );

  modport slave (
    input  en, gray,
    output binary, valid, step, overflow, wrap_cnt, error
  );

endinterface

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin
  import gray_monitor_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  logic acc;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    binary = '0;
    acc    = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc       = acc ^ gray[i];
      binary[i] = acc;
    end
  end

endmodule

// File: rtl/gray_monitor.sv
// Receive-side Gray code checker: decodes each enabled sample, flags legal +1 steps
// and wrap-arounds, counts wraps (saturating) and latches a sticky error on bad jumps.
module gray_monitor
  import gray_monitor_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  gray_monitor_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] decoded;
  logic [WIDTH-1:0] binary_q;
  logic [WIDTH-1:0] expected_next;
  logic             valid_q;
  logic             step_q;
  logic             overflow_q;
  logic [CNT_W-1:0] wrap_cnt_q;
  logic             error_q;

  gray2bin #(.WIDTH(WIDTH)) u_dec (
    .gray   (bus.gray),
    .binary (decoded)
  );

  // Wraps naturally at WIDTH bits, so all-ones + 1 compares equal to zero.
  assign expected_next = binary_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_WAIT;
      binary_q   <= '0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      overflow_q <= 1'b0;
      wrap_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      step_q     <= 1'b0;
      overflow_q <= 1'b0;
      if (bus.en) begin
        case (state)
          S_WAIT: begin
            binary_q <= decoded;
            valid_q  <= 1'b1;
            state    <= S_TRACK;
          end
          S_TRACK: begin
            if (decoded == binary_q) begin
              // Repeated sample: legal, nothing changes.
            end else if (decoded == expected_next) begin
              binary_q <= decoded;
              step_q   <= 1'b1;
              if (&binary_q) begin
                overflow_q <= 1'b1;
                if (wrap_cnt_q != CNT_MAX) wrap_cnt_q <= wrap_cnt_q + 1'b1;
              end
            end else begin
              binary_q <= decoded;
              error_q  <= 1'b1;
              state    <= S_FAULT;
            end
          end
          S_FAULT: begin
            binary_q <= decoded;
          end
          default: state <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.binary   = binary_q;
  assign bus.valid    = valid_q;
  assign bus.step     = step_q;
  assign bus.overflow = overflow_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.error    = error_q;

endmodule
